acc_unit: RTL and testbench
===========================

ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter LEN_W, default 8, width of burst length and carry counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of operands in the burst, sampled with start.
REQ-007 SHALL have port in_valid  input  1  operand valid.
REQ-008 SHALL have port in_data  input  DATA_W  operand.
REQ-009 SHALL have port in_ready  output  1  operand accepted when in_valid&&in_ready.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_sum  output  DATA_W  burst sum modulo 2^DATA_W.
REQ-012 SHALL have port out_carries  output  LEN_W  count of carry-outs from the MSB during the burst.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-014 SHALL have port busy  output  1  high in ACCUM and DONE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DONE.
REQ-016 SHALL, in IDLE with start=1 and len!=0, clear accumulator and carry count, load remaining=len, go to ACCUM next cycle.
REQ-017 SHALL, in IDLE with start=1 and len=0, go to DONE with out_sum=0, out_carries=0.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL drive in_ready=1 only in ACCUM, combinationally from state (not from in_valid).
REQ-020 SHALL, on each accepted operand, set acc <= acc+in_data truncated to DATA_W and decrement remaining.
REQ-021 SHALL increment the carry count when the addition carries out of bit DATA_W-1, saturating at 2^LEN_W-1.
REQ-022 SHALL go from ACCUM to DONE on acceptance of the operand with remaining=1; no further operand accepted in that burst.
REQ-023 SHALL assert out_valid the cycle after the last operand is accepted (latency 1), only in DONE.
REQ-024 SHALL hold out_sum and out_carries stable while out_valid=1 and out_ready=0.
REQ-025 SHALL return to IDLE the cycle after out_valid&&out_ready; a start in that same cycle is ignored (state not yet IDLE).
REQ-026 SHALL keep out_sum/out_carries equal to the last completed result while in IDLE and ACCUM (only out_valid qualifies them).
REQ-027 SHALL tolerate in_valid gaps in ACCUM with no state change.

Reset
REQ-028 SHALL, on rst=1 at any time, go to IDLE and clear acc, carry count, remaining, out_sum, out_carries to 0; in_ready, out_valid, busy = 0.
REQ-029 SHALL abandon any burst in progress on reset; no partial result is ever presented.

Structure
REQ-030 SHALL place the state enumeration and DATA_W/LEN_W defaults in shared package acc_pkg.
REQ-031 SHALL use one combinational sub-module acc_add32 (DATA_W-bit sum plus carry-out) for the accumulate adder.
REQ-032 SHALL keep all sequential logic in acc_unit.

Verification
REQ-033 SHALL test: start,len=3; operands 1,2,3 back-to-back; out_ready=1 -> out_valid one cycle after third accept, out_sum=6, out_carries=0.
REQ-034 SHALL test: len=2; operands 0xFFFFFFFF, 0x00000002 -> out_sum=0x00000001, out_carries=1.
REQ-035 SHALL test: start,len=0 -> next cycle out_valid=1, out_sum=0, out_carries=0, in_ready never asserted.
REQ-036 SHALL test: len=2, in_valid gapped, out_ready held 0 for 5 cycles -> outputs stable, busy=1, start pulses ignored, IDLE one cycle after out_ready=1.
REQ-037 SHALL test: len=4, rst asserted after 2 accepts -> immediately IDLE, all outputs 0; new burst len=1 operand 7 -> out_sum=7.
REQ-038 SHALL test: len=255, all operands 0xFFFFFFFF -> out_sum=0xFFFFFF01, out_carries=254.

Source files
------------

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared definitions for the burst accumulator: width
//               defaults and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_LEN_W  = 8;

    // Controller states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_add32.sv
`default_nettype none
// ============================================================================
// Module      : acc_add32
// Description : Combinational DATA_W-bit adder returning the truncated sum
//               and the carry out of the most significant bit.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_add32
    import acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out
);

    // Widen by one bit so the MSB carry lands in the top bit of the result.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule : acc_add32
`default_nettype wire

// File: rtl/acc_unit.sv
`default_nettype none
// ============================================================================
// Module      : acc_unit
// Description : Burst accumulator. A start request in IDLE loads a burst
//               length; that many operands are summed modulo 2^DATA_W while
//               MSB carry-outs are counted (saturating). The result is held
//               under a valid/ready handshake until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_unit
    import acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic [LEN_W-1:0]  out_carries,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_max = {LEN_W{1'b1}};

    acc_state_t        r_state;
    acc_state_t        w_next_state;

    logic [DATA_W-1:0] r_acc;
    logic [LEN_W-1:0]  r_carries;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_out_sum;
    logic [LEN_W-1:0]  r_out_carries;

    logic [DATA_W-1:0] w_sum;
    logic              w_carry;
    logic [LEN_W-1:0]  w_carries_next;
    logic              w_accept;
    logic              w_last;

    acc_add32 #(
        .DATA_W    (DATA_W)
    ) u_add (
        .a         (r_acc),
        .b         (in_data),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    assign w_accept       = in_valid && in_ready;
    assign w_last         = (r_remaining == c_len_one);
    assign w_carries_next = (w_carry && (r_carries != c_len_max)) ?
                            (r_carries + c_len_one) : r_carries;

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: accumulate accepted operands and capture the result on the
    // final operand so the outputs only change when a burst completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc         <= '0;
            r_carries     <= '0;
            r_remaining   <= '0;
            r_out_sum     <= '0;
            r_out_carries <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_carries   <= '0;
                        r_remaining <= len;
                        if (len == '0) begin
                            r_out_sum     <= '0;
                            r_out_carries <= '0;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_sum;
                        r_carries   <= w_carries_next;
                        r_remaining <= r_remaining - c_len_one;
                        if (w_last) begin
                            r_out_sum     <= w_sum;
                            r_out_carries <= w_carries_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum     = r_out_sum;
    assign out_carries = r_out_carries;

endmodule : acc_unit
`default_nettype wire

// File: tb/tb_acc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_unit
// Description : Scoreboard bench for acc_unit. Stimulus pushes the expected
//               {sum, carries} of each burst; a monitor pops and compares on
//               every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_unit;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_sum;
    logic [LEN_W-1:0]  out_carries;
    logic              out_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W+LEN_W-1:0] sb[$];

    acc_unit #(
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h/%0h required=none", out_sum, out_carries);
            end else begin
                logic [DATA_W+LEN_W-1:0] e;
                e = sb.pop_front();
                check("mon_sum", 64'(out_sum), 64'(e[DATA_W+LEN_W-1:LEN_W]));
                check("mon_carries", 64'(out_carries), 64'(e[LEN_W-1:0]));
            end
        end
    end

    // Issue a one-cycle start; returns at posedge+1 after the sampling edge.
    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send_op(input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Burst of three back-to-back operands.
        sb.push_back({32'd6, 8'd0});
        do_start(8'd3);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        send_op(32'd1);
        send_op(32'd2);
        check("t1_no_early_valid", 64'(out_valid), 64'd0);
        send_op(32'd3);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_in_ready_done", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("t1_back_idle", 64'(busy), 64'd0);

        // Carry out of the MSB.
        sb.push_back({32'h0000_0001, 8'd1});
        do_start(8'd2);
        send_op(32'hFFFF_FFFF);
        send_op(32'h0000_0002);
        @(posedge clk); #1;

        // Zero-length burst goes straight to DONE.
        sb.push_back({32'd0, 8'd0});
        do_start(8'd0);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_sum", 64'(out_sum), 64'd0);
        @(posedge clk); #1;
        check("t3_idle_in_ready", 64'(in_ready), 64'd0);
        check("t3_idle_busy", 64'(busy), 64'd0);

        // Gapped input, result held under back-pressure, starts ignored.
        sb.push_back({32'd30, 8'd0});
        out_ready = 1'b0;
        do_start(8'd2);
        send_op(32'd10);
        repeat (3) begin
            check("t4_gap_in_ready", 64'(in_ready), 64'd1);
            check("t4_gap_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        send_op(32'd20);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_sum", 64'(out_sum), 64'd30);
            check("t4_hold_carries", 64'(out_carries), 64'd0);
            check("t4_hold_busy", 64'(busy), 64'd1);
            start = 1'b1;
            len   = 8'd3;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_idle_valid", 64'(out_valid), 64'd0);
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_idle_sum_kept", 64'(out_sum), 64'd30);
        @(posedge clk); #1;
        check("t4_start_ignored", 64'(busy), 64'd0);

        // Reset in the middle of a burst.
        do_start(8'd4);
        send_op(32'd5);
        send_op(32'd6);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", 64'(in_ready), 64'd0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_sum", 64'(out_sum), 64'd0);
        check("t5_rst_carries", 64'(out_carries), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb.push_back({32'd7, 8'd0});
        do_start(8'd1);
        send_op(32'd7);
        @(posedge clk); #1;

        // Long burst: many saturating-free carries.
        sb.push_back({32'hFFFF_FF01, 8'd254});
        do_start(8'd255);
        for (int i = 0; i < 255; i++) send_op(32'hFFFF_FFFF);
        @(posedge clk); #1;

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_acc_unit
`default_nettype wire
